// File: rtl/rf_mp.sv
// rf_mp: multi-port register file with pending scoreboard; define RF_BYPASS_EN for write-to-read forwarding
module rf_mp #(
  parameter int DW = 32,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*DW-1:0] wr_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [AW:0]       pend_cnt
);
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0] pend_cnt_q, pend_cnt_d;
  logic [NRD-1:0] hit;
  assign pend_cnt = pend_cnt_q;
  // next register contents: later write ports overwrite earlier ones
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && !(ZERO_REG != 0 && wr_addr[k*AW +: AW] == '0))
        regs_d[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
  end
  // next pending vector: writeback clears, issue sets (newer producer wins), flush clears all
  always_comb begin
    pend_d = pend_q;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k]) pend_d[wr_addr[k*AW +: AW]] = 1'b0;
    if (iss_en) pend_d[iss_addr] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
    if (flush) pend_d = '0;
    pend_cnt_d = '0;
    for (int i = 0; i < NREG; i++) pend_cnt_d = pend_cnt_d + (AW+1)'(pend_d[i]);
  end
  // read ports: stored value, optionally overridden by a same-cycle write to the same address
  always_comb begin
    hit = '0;
    for (int j = 0; j < NRD; j++) begin
      rd_data[j*DW +: DW] = regs_q[rd_addr[j*AW +: AW]];
`ifdef RF_BYPASS_EN
      for (int k = 0; k < NWR; k++)
        if (rst_n && wr_en[k] && wr_addr[k*AW +: AW] == rd_addr[j*AW +: AW] &&
            !(ZERO_REG != 0 && rd_addr[j*AW +: AW] == '0)) begin
          hit[j] = 1'b1;
          rd_data[j*DW +: DW] = wr_data[k*DW +: DW];
        end
`endif
    end
  end
  // a forwarded result means the consumer no longer has to wait
  always_comb begin
    for (int j = 0; j < NRD; j++) rd_busy[j] = pend_q[rd_addr[j*AW +: AW]] & ~hit[j];
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: directed table-driven bench for rf_mp (default parameters)
module tb_rf_mp;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] wr_en;
  logic [9:0] wr_addr;
  logic [63:0] wr_data;
  logic [9:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic iss_en;
  logic [4:0] iss_addr;
  logic flush;
  logic [5:0] pend_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [1:0] we; logic [4:0] wa0; logic [31:0] wd0; logic [4:0] wa1; logic [31:0] wd1;
    logic [4:0] ra0; logic [4:0] ra1; logic ie; logic [4:0] ia; logic fl;
    logic [31:0] e0; logic [31:0] e1; logic [1:0] eb; logic [5:0] ec;
  } vec_t;
  vec_t v [14];
  rf_mp dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .pend_cnt(pend_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask
  task automatic idle();
    wr_en = 2'b00;
    iss_en = 1'b0;
    flush = 1'b0;
  endtask
  task automatic edge_then_idle();
    @(posedge clk);
    #1 idle();
    #1;
  endtask
  initial begin
    v[0]  = '{2'b11, 5'd5,  32'h11111111, 5'd5,  32'h22222222, 5'd5,  5'd0, 1'b0, 5'd0,  1'b0, 32'h22222222, 32'h0, 2'b00, 6'd0};
    v[1]  = '{2'b11, 5'd7,  32'hCAFEF00D, 5'd8,  32'h12345678, 5'd7,  5'd8, 1'b0, 5'd0,  1'b0, 32'hCAFEF00D, 32'h12345678, 2'b00, 6'd0};
    v[2]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd3,  5'd5, 1'b1, 5'd3,  1'b0, 32'h0, 32'h22222222, 2'b01, 6'd1};
    v[3]  = '{2'b10, 5'd0,  32'h0,        5'd3,  32'h33,       5'd3,  5'd3, 1'b0, 5'd0,  1'b0, 32'h33, 32'h33, 2'b00, 6'd0};
    v[4]  = '{2'b01, 5'd3,  32'h44,       5'd0,  32'h0,        5'd3,  5'd7, 1'b1, 5'd3,  1'b0, 32'h44, 32'hCAFEF00D, 2'b01, 6'd1};
    v[5]  = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        5'd0,  5'd3, 1'b1, 5'd0,  1'b0, 32'h0, 32'h44, 2'b10, 6'd1};
    v[6]  = '{2'b10, 5'd0,  32'h0,        5'd3,  32'h55,       5'd3,  5'd0, 1'b0, 5'd0,  1'b0, 32'h55, 32'h0, 2'b00, 6'd0};
    v[7]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd1,  5'd0, 1'b1, 5'd1,  1'b0, 32'h0, 32'h0, 2'b01, 6'd1};
    v[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd2,  5'd1, 1'b1, 5'd2,  1'b0, 32'h0, 32'h0, 2'b11, 6'd2};
    v[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd4,  5'd1, 1'b1, 5'd4,  1'b0, 32'h0, 32'h0, 2'b11, 6'd3};
    v[10] = '{2'b01, 5'd10, 32'hAAAA5555, 5'd0,  32'h0,        5'd9,  5'd10, 1'b1, 5'd9, 1'b1, 32'h0, 32'hAAAA5555, 2'b00, 6'd0};
    v[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd31, 5'd2, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0, 2'b01, 6'd1};
    v[12] = '{2'b01, 5'd6,  32'h66,       5'd6,  32'h77,       5'd6,  5'd5, 1'b0, 5'd0,  1'b0, 32'h66, 32'h22222222, 2'b00, 6'd1};
    v[13] = '{2'b10, 5'd0,  32'h0,        5'd31, 32'h31313131, 5'd31, 5'd6, 1'b0, 5'd0,  1'b0, 32'h31313131, 32'h66, 2'b00, 6'd0};
    rst_n = 1'b0;
    wr_en = 2'b11;
    wr_addr = {5'd2, 5'd1};
    wr_data = {32'hDEADBEEF, 32'hDEADBEEF};
    rd_addr = {5'd2, 5'd1};
    iss_en = 1'b1;
    iss_addr = 5'd1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", rd_data, 64'h0);
    chk("rst_busy", {62'h0, rd_busy}, 64'h0);
    chk("rst_cnt", {58'h0, pend_cnt}, 64'h0);
    idle();
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd_addr = {5'd0, 5'(i)};
      #1 chk($sformatf("rst_r%0d", i), {32'h0, rd_data[31:0]}, 64'h0);
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wr_en = v[i].we;
      wr_addr = {v[i].wa1, v[i].wa0};
      wr_data = {v[i].wd1, v[i].wd0};
      rd_addr = {v[i].ra1, v[i].ra0};
      iss_en = v[i].ie;
      iss_addr = v[i].ia;
      flush = v[i].fl;
      edge_then_idle();
      chk($sformatf("v%0d_rd0", i), {32'h0, rd_data[31:0]}, {32'h0, v[i].e0});
      chk($sformatf("v%0d_rd1", i), {32'h0, rd_data[63:32]}, {32'h0, v[i].e1});
      chk($sformatf("v%0d_busy", i), {62'h0, rd_busy}, {62'h0, v[i].eb});
      chk($sformatf("v%0d_cnt", i), {58'h0, pend_cnt}, {58'h0, v[i].ec});
    end
    @(negedge clk);
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd12};
    wr_data = {32'h0, 32'hCAFEF00D};
    rd_addr = {5'd0, 5'd12};
    #1 chk("byp_same", {32'h0, rd_data[31:0]}, BYP ? 64'hCAFEF00D : 64'h0);
    edge_then_idle();
    chk("byp_next", {32'h0, rd_data[31:0]}, 64'hCAFEF00D);
    @(negedge clk);
    iss_en = 1'b1;
    iss_addr = 5'd13;
    rd_addr = {5'd0, 5'd13};
    edge_then_idle();
    chk("sb_busy", {63'h0, rd_busy[0]}, 64'h1);
    chk("sb_cnt", {58'h0, pend_cnt}, 64'h1);
    @(negedge clk);
    wr_en = 2'b10;
    wr_addr = {5'd13, 5'd0};
    wr_data = {32'h0D13D13D, 32'h0};
    #1 chk("wb_busy_same", {63'h0, rd_busy[0]}, BYP ? 64'h0 : 64'h1);
    chk("wb_rd_same", {32'h0, rd_data[31:0]}, BYP ? 64'h0D13D13D : 64'h0);
    edge_then_idle();
    chk("wb_busy_next", {63'h0, rd_busy[0]}, 64'h0);
    chk("wb_cnt", {58'h0, pend_cnt}, 64'h0);
    chk("wb_rd_next", {32'h0, rd_data[31:0]}, 64'h0D13D13D);
    @(negedge clk);
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'h0, 32'hFFFFFFFF};
    rd_addr = {5'd0, 5'd0};
    #1 chk("zero_byp", {32'h0, rd_data[31:0]}, 64'h0);
    chk("zero_busy", {62'h0, rd_busy}, 64'h0);
    edge_then_idle();
    @(negedge clk);
    iss_en = 1'b1;
    iss_addr = 5'd20;
    rd_addr = {5'd20, 5'd5};
    edge_then_idle();
    chk("pre_rst_rd", {32'h0, rd_data[31:0]}, 64'h22222222);
    chk("pre_rst_busy", {62'h0, rd_busy}, 64'h2);
    chk("pre_rst_cnt", {58'h0, pend_cnt}, 64'h1);
    #1 rst_n = 1'b0;
    #1 chk("arst_rd", rd_data, 64'h0);
    chk("arst_busy", {62'h0, rd_busy}, 64'h0);
    chk("arst_cnt", {58'h0, pend_cnt}, 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
